// File: rtl/ctrl_decode_stage_pkg.sv
// Shared definitions for the decode/control stage: opcode and function
// encodings, FSM state encoding and the registered control bundle.
// CTRL_MULDIV_EN adds the multi-cycle multiply/divide state.
package ctrl_decode_stage_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;

  localparam logic [4:0] FN_ADD = 5'b00000;
  localparam logic [4:0] FN_SUB = 5'b00001;
  localparam logic [4:0] FN_AND = 5'b00010;
  localparam logic [4:0] FN_OR  = 5'b00011;
  localparam logic [4:0] FN_SLL = 5'b00100;
  localparam logic [4:0] FN_SRA = 5'b00101;
  localparam logic [4:0] FN_MUL = 5'b00110;
  localparam logic [4:0] FN_DIV = 5'b00111;

`ifdef CTRL_MULDIV_EN
  typedef enum logic [1:0] {ST_ISSUE = 2'd0, ST_BUBBLE = 2'd1, ST_MD_BUSY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_ISSUE = 2'd0, ST_BUBBLE = 2'd1} state_t;
`endif

  // Single-bit controls carried with every bundle.
  typedef struct packed {
    logic write_en;
    logic rdst;
    logic alu_in_b;
    logic wren;
    logic rwd;      // load: write-back from memory, also marks a load for the interlock
    logic jp;
    logic br;
    logic exp;
    logic jal;
    logic jr;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational opcode/function -> control bundle decoder.
// With CTRL_MULDIV_EN undefined, mul/div functions decode as illegal.
module ctrl_decode_comb
  import ctrl_decode_stage_pkg::*;
#(
  parameter int OPW    = 5,
  parameter int ALUOPW = 5,
  parameter int REGW   = 5
) (
  input  logic [OPW-1:0]    opcode,
  input  logic [ALUOPW-1:0] raw_aluop,
  input  logic [REGW-1:0]   rt,
  input  logic [REGW-1:0]   rd,
  output ctrl_t             ctrl,
  output logic [ALUOPW-1:0] aluop,
`ifdef CTRL_MULDIV_EN
  output logic              md_op,
`endif
  output logic [REGW-1:0]   wdst
);

  // Decode table; unknown encodings yield an all-zero bundle with illegal set.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    ctrl  = '0;
    aluop = '0;
    wdst  = '0;
`ifdef CTRL_MULDIV_EN
    md_op = 1'b0;
`endif
    case (opcode)
      OP_RTYPE: begin
        ctrl.write_en = 1'b1;
        ctrl.rdst     = 1'b1;
        aluop         = raw_aluop;
        wdst          = rd;
        case (raw_aluop)
          FN_ADD, FN_SUB: ctrl.exp = 1'b1;
          FN_AND, FN_OR, FN_SLL, FN_SRA: ;
`ifdef CTRL_MULDIV_EN
          FN_MUL, FN_DIV: begin
            ctrl.exp = 1'b1;
            md_op    = 1'b1;
          end
`endif
          default: begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
            aluop        = '0;
            wdst         = '0;
          end
        endcase
      end
      OP_ADDI: begin
        ctrl.write_en = 1'b1;
        ctrl.alu_in_b = 1'b1;
        ctrl.exp      = 1'b1;
        wdst          = rt;
      end
      OP_LW: begin
        ctrl.write_en = 1'b1;
        ctrl.alu_in_b = 1'b1;
        ctrl.rwd      = 1'b1;
        wdst          = rt;
      end
      OP_SW: begin
        ctrl.wren     = 1'b1;
        ctrl.alu_in_b = 1'b1;
      end
      OP_BNE: begin
        ctrl.br = 1'b1;
        aluop   = ALUOPW'(1);
      end
      OP_J:   ctrl.jp = 1'b1;
      OP_JAL: begin
        ctrl.jp       = 1'b1;
        ctrl.jal      = 1'b1;
        ctrl.write_en = 1'b1;
        wdst          = REGW'(31);
      end
      OP_JR:   ctrl.jr = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode/control stage with valid/ready handshake, load-use
// interlock, flush and illegal-opcode flag. Defining CTRL_MULDIV_EN adds
// the multiply/divide occupancy counter, MD_BUSY state and md_start pulse.
module ctrl_decode_stage
  import ctrl_decode_stage_pkg::*;
#(
  parameter int OPW    = 5,
  parameter int ALUOPW = 5,
  parameter int REGW   = 5,
  parameter int MD_LAT = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPW-1:0]    opcode,
  input  logic [ALUOPW-1:0] raw_aluop,
  input  logic [REGW-1:0]   rs,
  input  logic [REGW-1:0]   rt,
  input  logic [REGW-1:0]   rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ctrl_writeEnable,
  output logic              Rdst,
  output logic              ALUinB,
  output logic              wren,
  output logic              Rwd,
  output logic              JP,
  output logic              BR,
  output logic              EXP,
  output logic              JAL,
  output logic              JR,
  output logic [ALUOPW-1:0] aluop,
  output logic [REGW-1:0]   wdst,
  output logic              md_start,
  output logic              illegal
);

  ctrl_t             dec_ctrl, out_ctrl;
  logic [ALUOPW-1:0] dec_aluop, out_aluop;
  logic [REGW-1:0]   dec_wdst, out_wdst;
  state_t            state, state_nxt;
  logic              ld_valid;
  logic [REGW-1:0]   ld_reg;
  logic              can_load, hazard, accept, go_bubble;

`ifdef CTRL_MULDIV_EN
  localparam int CNTW = $clog2(MD_LAT);
  logic            dec_md;
  logic [CNTW-1:0] md_cnt;
  logic            md_start_q;
`endif

  ctrl_decode_comb #(.OPW(OPW), .ALUOPW(ALUOPW), .REGW(REGW)) u_decode (
    .opcode    (opcode),
    .raw_aluop (raw_aluop),
    .rt        (rt),
    .rd        (rd),
    .ctrl      (dec_ctrl),
    .aluop     (dec_aluop),
`ifdef CTRL_MULDIV_EN
    .md_op     (dec_md),
`endif
    .wdst      (dec_wdst)
  );

  // The output register may take a new bundle when empty or being drained.
  assign can_load = !out_valid || out_ready;
  // Tracker only ever holds a non-zero load destination, so r0 never interlocks.
  assign hazard   = in_valid && ld_valid && ((rs == ld_reg) || (rt == ld_reg));

  // Next-state, handshake and acceptance decisions.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    go_bubble = 1'b0;
    unique case (state)
      ST_ISSUE: begin
        in_ready = can_load && !hazard && !flush;
        if (hazard && can_load && !flush) begin
          go_bubble = 1'b1;
          state_nxt = ST_BUBBLE;
        end
      end
      ST_BUBBLE: begin
        in_ready  = can_load && !flush;
        state_nxt = ST_ISSUE;
      end
`ifdef CTRL_MULDIV_EN
      ST_MD_BUSY: begin
        if (md_cnt == '0) state_nxt = ST_ISSUE;
      end
`endif
      default: state_nxt = ST_ISSUE;
    endcase
    accept = in_ready && in_valid;
`ifdef CTRL_MULDIV_EN
    if (accept && dec_md) state_nxt = ST_MD_BUSY;
`endif
    if (flush) state_nxt = ST_ISSUE;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= ST_ISSUE;
    else       state <= state_nxt;
  end

  // Load-use tracker: destination of the last accepted load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ld_valid <= 1'b0;
      ld_reg   <= '0;
    end else if (flush || go_bubble) begin
      ld_valid <= 1'b0;
      ld_reg   <= '0;
    end else if (accept) begin
      ld_valid <= dec_ctrl.rwd && (dec_wdst != '0);
      ld_reg   <= dec_wdst;
    end
  end

  // Output bundle register; holds while stalled, dropped by flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_aluop <= '0;
      out_wdst  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (can_load) begin
      out_valid <= accept;
      if (accept) begin
        out_ctrl  <= dec_ctrl;
        out_aluop <= dec_aluop;
        out_wdst  <= dec_wdst;
      end
    end
  end

`ifdef CTRL_MULDIV_EN
  // Multiply/divide occupancy counter and one-cycle start pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_cnt     <= '0;
      md_start_q <= 1'b0;
    end else begin
      md_start_q <= accept && dec_md && !flush;
      if (flush)                md_cnt <= '0;
      else if (accept && dec_md) md_cnt <= CNTW'(MD_LAT - 1);
      else if (md_cnt != '0)    md_cnt <= md_cnt - CNTW'(1);
    end
  end
  assign md_start = md_start_q;
`else
  assign md_start = 1'b0;
`endif

  assign ctrl_writeEnable = out_ctrl.write_en;
  assign Rdst             = out_ctrl.rdst;
  assign ALUinB           = out_ctrl.alu_in_b;
  assign wren             = out_ctrl.wren;
  assign Rwd              = out_ctrl.rwd;
  assign JP               = out_ctrl.jp;
  assign BR               = out_ctrl.br;
  assign EXP              = out_ctrl.exp;
  assign JAL              = out_ctrl.jal;
  assign JR               = out_ctrl.jr;
  assign illegal          = out_ctrl.illegal;
  assign aluop            = out_aluop;
  assign wdst             = out_wdst;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage: table of single-instruction decodes
// plus hand-written load-use, back-pressure, flush, reset and mul/div sequences.
module tb_ctrl_decode_stage;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, flush, out_valid, out_ready;
  logic [4:0] opcode, raw_aluop, rs, rt, rd, aluop, wdst;
  logic       ctrl_writeEnable, Rdst, ALUinB, wren, Rwd, JP, BR, EXP, JAL, JR;
  logic       md_start, illegal;
  logic [9:0] dut_ctrl;

  int n_checks = 0;
  int n_pass   = 0;

  ctrl_decode_stage #(.OPW(5), .ALUOPW(5), .REGW(5), .MD_LAT(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .raw_aluop(raw_aluop), .rs(rs), .rt(rt), .rd(rd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_writeEnable(ctrl_writeEnable), .Rdst(Rdst), .ALUinB(ALUinB),
    .wren(wren), .Rwd(Rwd), .JP(JP), .BR(BR), .EXP(EXP), .JAL(JAL), .JR(JR),
    .aluop(aluop), .wdst(wdst), .md_start(md_start), .illegal(illegal)
  );

  always #5 clock = ~clock;

  // Control bits in order {we, Rdst, ALUinB, wren, Rwd, JP, BR, EXP, JAL, JR}.
  assign dut_ctrl = {ctrl_writeEnable, Rdst, ALUinB, wren, Rwd, JP, BR, EXP, JAL, JR};

  typedef struct {
    string      name;
    logic [4:0] op, fn, rt, rd;
    logic [9:0] ctrl;
    logic [4:0] aluop, wdst;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input logic [4:0] op, fn, t, d,
                              input logic [9:0] c, input logic [4:0] al, wd, input logic il);
    vec_t v;
    v.name = nm; v.op = op; v.fn = fn; v.rt = t; v.rd = d;
    v.ctrl = c; v.aluop = al; v.wdst = wd; v.ill = il;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic drive(input logic v, input logic [4:0] op, fn, s, t, d);
    in_valid = v; opcode = op; raw_aluop = fn; rs = s; rt = t; rd = d;
  endtask

  task automatic check_bundle(input string nm, input logic [9:0] c,
                              input logic [4:0] al, wd, input logic il);
    check({nm, ".out_valid"}, 32'(out_valid), 32'd1);
    check({nm, ".ctrl"},      32'(dut_ctrl),  32'(c));
    check({nm, ".aluop"},     32'(aluop),     32'(al));
    check({nm, ".wdst"},      32'(wdst),      32'(wd));
    check({nm, ".illegal"},   32'(illegal),   32'(il));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);

    //               name        op        fn        rt     rd     ctrl           aluop  wdst   ill
    vecs.push_back(mk("add",     5'b00000, 5'b00000, 5'd2,  5'd3,  10'b1100000100, 5'd0, 5'd3,  1'b0));
    vecs.push_back(mk("sub",     5'b00000, 5'b00001, 5'd2,  5'd4,  10'b1100000100, 5'd1, 5'd4,  1'b0));
    vecs.push_back(mk("and",     5'b00000, 5'b00010, 5'd2,  5'd5,  10'b1100000000, 5'd2, 5'd5,  1'b0));
    vecs.push_back(mk("sra",     5'b00000, 5'b00101, 5'd2,  5'd6,  10'b1100000000, 5'd5, 5'd6,  1'b0));
    vecs.push_back(mk("addi",    5'b00101, 5'b00000, 5'd2,  5'd7,  10'b1010000100, 5'd0, 5'd2,  1'b0));
    vecs.push_back(mk("sw",      5'b00111, 5'b00000, 5'd2,  5'd7,  10'b0011000000, 5'd0, 5'd0,  1'b0));
    vecs.push_back(mk("bne",     5'b00010, 5'b00000, 5'd2,  5'd7,  10'b0000001000, 5'd1, 5'd0,  1'b0));
    vecs.push_back(mk("j",       5'b00001, 5'b00000, 5'd2,  5'd7,  10'b0000010000, 5'd0, 5'd0,  1'b0));
    vecs.push_back(mk("jal",     5'b00011, 5'b00000, 5'd2,  5'd7,  10'b1000010010, 5'd0, 5'd31, 1'b0));
    vecs.push_back(mk("jr",      5'b00100, 5'b00000, 5'd2,  5'd7,  10'b0000000001, 5'd0, 5'd0,  1'b0));
    vecs.push_back(mk("op11111", 5'b11111, 5'b00011, 5'd2,  5'd7,  10'b0000000000, 5'd0, 5'd0,  1'b1));
    vecs.push_back(mk("fn01010", 5'b00000, 5'b01010, 5'd2,  5'd7,  10'b0000000000, 5'd0, 5'd0,  1'b1));
`ifndef CTRL_MULDIV_EN
    vecs.push_back(mk("mul_off", 5'b00000, 5'b00110, 5'd2,  5'd7,  10'b0000000000, 5'd0, 5'd0,  1'b1));
`endif
    vecs.push_back(mk("lw",      5'b01000, 5'b00000, 5'd9,  5'd7,  10'b1010100000, 5'd0, 5'd9,  1'b0));

    // Reset values
    repeat (2) next_cycle();
    mid();
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.ctrl",      32'(dut_ctrl),  32'd0);
    check("rst.aluop",     32'(aluop),     32'd0);
    check("rst.wdst",      32'(wdst),      32'd0);
    check("rst.illegal",   32'(illegal),   32'd0);
    check("rst.md_start",  32'(md_start),  32'd0);
    next_cycle();
    reset = 1'b0;
    mid();
    check("rst.in_ready", 32'(in_ready), 32'd1);
    next_cycle();

    // Table: one instruction, one idle cycle, check bundle one cycle after accept
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].fn, 5'd1, vecs[i].rt, vecs[i].rd);
      mid();
      check({vecs[i].name, ".in_ready"}, 32'(in_ready), 32'd1);
      next_cycle();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
      mid();
      check_bundle(vecs[i].name, vecs[i].ctrl, vecs[i].aluop, vecs[i].wdst, vecs[i].ill);
      check({vecs[i].name, ".md_start"}, 32'(md_start), 32'd0);
      next_cycle();
    end

    // Load-use: lw rt=5 then add rs=5 -> exactly one empty cycle between bundles
    drive(1'b1, 5'b01000, 5'd0, 5'd1, 5'd5, 5'd0);
    mid();
    check("lu.lw_ready", 32'(in_ready), 32'd1);
    next_cycle();
    drive(1'b1, 5'b00000, 5'b00000, 5'd5, 5'd2, 5'd7);
    mid();
    check("lu.lw_out", 32'(out_valid & Rwd), 32'd1);
    check("lu.stall_ready", 32'(in_ready), 32'd0);
    next_cycle();
    mid();
    check("lu.bubble_valid", 32'(out_valid), 32'd0);
    check("lu.bubble_ready", 32'(in_ready), 32'd1);
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    mid();
    check_bundle("lu.add", 10'b1100000100, 5'd0, 5'd7, 1'b0);
    next_cycle();

    // lw to r0 followed by a use of r0: no bubble
    drive(1'b1, 5'b01000, 5'd0, 5'd1, 5'd0, 5'd0);
    next_cycle();
    drive(1'b1, 5'b00000, 5'b00000, 5'd0, 5'd0, 5'd8);
    mid();
    check("r0.ready", 32'(in_ready), 32'd1);
    check("r0.lw_valid", 32'(out_valid), 32'd1);
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    mid();
    check_bundle("r0.add", 10'b1100000100, 5'd0, 5'd8, 1'b0);
    next_cycle();

    // Back-pressure: bundle held stable for three cycles, then released
    drive(1'b1, 5'b00000, 5'b00000, 5'd1, 5'd2, 5'd10);
    next_cycle();
    out_ready = 1'b0;
    drive(1'b1, 5'b00000, 5'b00011, 5'd1, 5'd2, 5'd11);
    for (int i = 0; i < 3; i++) begin
      mid();
      check($sformatf("bp.hold%0d", i), 32'({out_valid, wdst, in_ready}), 32'({1'b1, 5'd10, 1'b0}));
      next_cycle();
    end
    out_ready = 1'b1;
    mid();
    check("bp.release_ready", 32'(in_ready), 32'd1);
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    mid();
    check_bundle("bp.or", 10'b1100000000, 5'd3, 5'd11, 1'b0);
    next_cycle();

    // Flush drops the presented instruction and the output bundle
    drive(1'b1, 5'b00000, 5'b00000, 5'd1, 5'd2, 5'd12);
    flush = 1'b1;
    mid();
    check("fl.ready", 32'(in_ready), 32'd0);
    next_cycle();
    flush = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    mid();
    check("fl.out_valid", 32'(out_valid), 32'd0);
    next_cycle();

    // Flush clears the load tracker: the would-be dependent is accepted at once
    drive(1'b1, 5'b01000, 5'd0, 5'd1, 5'd6, 5'd0);
    next_cycle();
    drive(1'b1, 5'b00000, 5'b00000, 5'd6, 5'd2, 5'd12);
    flush = 1'b1;
    mid();
    check("fl2.ready", 32'(in_ready), 32'd0);
    next_cycle();
    flush = 1'b0;
    mid();
    check("fl2.ready_after", 32'(in_ready), 32'd1);
    check("fl2.out_valid", 32'(out_valid), 32'd0);
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    mid();
    check_bundle("fl2.add", 10'b1100000100, 5'd0, 5'd12, 1'b0);
    next_cycle();

`ifdef CTRL_MULDIV_EN
    // mul: md_start one cycle, in_ready low MD_LAT cycles, next accepted after
    drive(1'b1, 5'b00000, 5'b00110, 5'd1, 5'd2, 5'd13);
    mid();
    check("md.ready", 32'(in_ready), 32'd1);
    next_cycle();
    drive(1'b1, 5'b00000, 5'b00000, 5'd1, 5'd2, 5'd14);
    for (int i = 0; i < 4; i++) begin
      mid();
      check($sformatf("md.busy%0d", i), 32'(in_ready), 32'd0);
      if (i == 0) begin
        check_bundle("md.mul", 10'b1100000100, 5'd6, 5'd13, 1'b0);
        check("md.start", 32'(md_start), 32'd1);
      end else begin
        check($sformatf("md.start_off%0d", i), 32'(md_start), 32'd0);
      end
      next_cycle();
    end
    mid();
    check("md.ready_again", 32'(in_ready), 32'd1);
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    mid();
    check_bundle("md.next", 10'b1100000100, 5'd0, 5'd14, 1'b0);
    next_cycle();

    // flush during MD_BUSY returns to ISSUE immediately
    drive(1'b1, 5'b00000, 5'b00111, 5'd1, 5'd2, 5'd15);
    next_cycle();
    drive(1'b1, 5'b00000, 5'b00000, 5'd1, 5'd2, 5'd16);
    flush = 1'b1;
    mid();
    check("mdf.ready", 32'(in_ready), 32'd0);
    check("mdf.start", 32'(md_start), 32'd1);
    next_cycle();
    flush = 1'b0;
    mid();
    check("mdf.out_valid", 32'(out_valid), 32'd0);
    check("mdf.md_start", 32'(md_start), 32'd0);
    check("mdf.ready_after", 32'(in_ready), 32'd1);
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    mid();
    check_bundle("mdf.add", 10'b1100000100, 5'd0, 5'd16, 1'b0);
    next_cycle();
`endif

    // Asynchronous reset in the middle of a back-pressure stall
    drive(1'b1, 5'b00000, 5'b00000, 5'd1, 5'd2, 5'd20);
    next_cycle();
    out_ready = 1'b0;
    mid();
    check("ar.stalled", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("ar.out_valid", 32'(out_valid), 32'd0);
    check("ar.wdst", 32'(wdst), 32'd0);
    next_cycle();
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    mid();
    check("ar.in_ready", 32'(in_ready), 32'd1);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
